adc_acq_seq: RTL and testbench

Acquisition sequencer for the two-channel ADC path; sits directly upstream and downstream of the SPI read stage. Issues start-read pulses, alternates channel 0 and channel 1, and captures each 12-bit result on end-of-read. Averages 2^AvgLog2 samples per channel and presents both averages with a one-cycle valid pulse.

---
 rtl/adc_acq_pkg.sv | 24 ++
 rtl/adc_acq_seq_period_cnt.sv | 29 ++
 rtl/adc_acq_seq.sv | 167 ++++++++++++++++
 tb/tb_adc_acq_seq.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_acq_pkg.sv
// Shared definitions for the two-channel ADC acquisition sequencer:
// FSM state encoding, channel constants, default read timeout and a
// counter-width helper.
package adc_acq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_WAIT_EOR = 3'd2,
    ST_PAIR     = 3'd3,
    ST_WAIT_PER = 3'd4
  } state_t;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  localparam int unsigned DefaultTimeout = 4096;

  // Bits needed to hold the value n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adc_acq_seq_period_cnt.sv
// period_cnt: loadable down-counter with a zero flag. Saturates at zero.
// Used for the inter-pair idle period and for the optional read timeout.
module period_cnt #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [Width-1:0] cnt;

  // Load takes priority over decrement; hold once zero is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/adc_acq_seq.sv
// adc_acq_seq: acquisition sequencer for the two-channel ADC path.
// Issues start-read pulses, alternates channel 0 / channel 1, accumulates
// 2^AvgLog2 pairs and presents both truncated averages with a valid pulse.
// Optional read timeout with retry is compiled in by ADC_ACQ_TIMEOUT_EN.
module adc_acq_seq
  import adc_acq_pkg::*;
#(
  parameter int unsigned Width         = 12,
  parameter int unsigned AvgLog2       = 3,
  parameter int unsigned PeriodCycles  = 1000,
  parameter int unsigned TimeoutCycles = DefaultTimeout
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [Width-1:0] din_i,
  input  logic             eor_i,
  output logic             strr_o,
  output logic             ch_o,
  output logic [Width-1:0] ch0_o,
  output logic [Width-1:0] ch1_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             err_o
);

  localparam int unsigned AccW = Width + AvgLog2;
  localparam int unsigned PcW  = (AvgLog2 > 0) ? AvgLog2 : 1;
  localparam int unsigned PerW = cnt_width(PeriodCycles);
  localparam logic [PcW-1:0] PairMax = PcW'((1 << AvgLog2) - 1);

  if (AvgLog2 > 6 || PeriodCycles < 1 || TimeoutCycles < 1) begin : g_bad_cfg
    $error("adc_acq_seq: illegal parameter set");
  end

  state_t          state;
  logic [AccW-1:0] acc0;
  logic [AccW-1:0] acc1;
  logic [PcW-1:0]  pair_cnt;
  logic            per_zero;

  period_cnt #(
    .Width(PerW)
  ) u_per_cnt (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (state == ST_PAIR),
    .load_val (PerW'(PeriodCycles - 1)),
    .dec      (state == ST_WAIT_PER),
    .zero     (per_zero)
  );

`ifdef ADC_ACQ_TIMEOUT_EN
  localparam int unsigned ToW = cnt_width(TimeoutCycles);
  logic to_zero;

  // Armed in START, runs down while waiting for the end-of-read strobe.
  period_cnt #(
    .Width(ToW)
  ) u_to_cnt (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (state == ST_START),
    .load_val (ToW'(TimeoutCycles - 1)),
    .dec      (state == ST_WAIT_EOR),
    .zero     (to_zero)
  );
`else
  assign err_o = 1'b0;
`endif

  // Sequencer FSM; all outputs registered. strr_o/busy_o are set on the
  // edge that enters the state they describe so they line up with it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      strr_o   <= 1'b0;
      ch_o     <= CH0;
      ch0_o    <= '0;
      ch1_o    <= '0;
      valid_o  <= 1'b0;
      busy_o   <= 1'b0;
      acc0     <= '0;
      acc1     <= '0;
      pair_cnt <= '0;
`ifdef ADC_ACQ_TIMEOUT_EN
      err_o    <= 1'b0;
`endif
    end else begin
      strr_o  <= 1'b0;
      valid_o <= 1'b0;
`ifdef ADC_ACQ_TIMEOUT_EN
      err_o   <= 1'b0;
`endif
      unique case (state)
        ST_IDLE: begin
          acc0     <= '0;
          acc1     <= '0;
          pair_cnt <= '0;
          ch_o     <= CH0;
          if (en_i) begin
            state  <= ST_START;
            strr_o <= 1'b1;
            busy_o <= 1'b1;
          end
        end
        ST_START: begin
          state <= ST_WAIT_EOR;
        end
        ST_WAIT_EOR: begin
          if (eor_i) begin
            if (ch_o == CH0) begin
              acc0   <= acc0 + AccW'(din_i);
              ch_o   <= CH1;
              state  <= ST_START;
              strr_o <= 1'b1;
            end else begin
              acc1  <= acc1 + AccW'(din_i);
              state <= ST_PAIR;
            end
          end
`ifdef ADC_ACQ_TIMEOUT_EN
          else if (to_zero) begin
            err_o  <= 1'b1;
            state  <= ST_START;
            strr_o <= 1'b1;
          end
`endif
        end
        ST_PAIR: begin
          if (pair_cnt == PairMax) begin
            ch0_o    <= acc0[AccW-1:AvgLog2];
            ch1_o    <= acc1[AccW-1:AvgLog2];
            valid_o  <= 1'b1;
            acc0     <= '0;
            acc1     <= '0;
            pair_cnt <= '0;
          end else begin
            pair_cnt <= pair_cnt + 1'b1;
          end
          ch_o  <= CH0;
          state <= ST_WAIT_PER;
        end
        ST_WAIT_PER: begin
          if (per_zero) begin
            if (en_i) begin
              state  <= ST_START;
              strr_o <= 1'b1;
            end else begin
              // Leaving for IDLE drops any partial average.
              state    <= ST_IDLE;
              busy_o   <= 1'b0;
              acc0     <= '0;
              acc1     <= '0;
              pair_cnt <= '0;
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_acq_seq.sv
// Self-checking bench for adc_acq_seq (AvgLog2=2, PeriodCycles=20,
// TimeoutCycles=50). Define ADC_ACQ_TIMEOUT_EN to exercise the timeout path.
module tb_adc_acq_seq;

  localparam int unsigned W    = 12;
  localparam int unsigned AVG  = 2;
  localparam int unsigned PER  = 20;
  localparam int unsigned TO   = 50;
  localparam int unsigned NAVG = 1 << AVG;

  logic         clk;
  logic         rst;
  logic         en;
  logic [W-1:0] din;
  logic         eor;
  logic         strr_o;
  logic         ch_o;
  logic [W-1:0] ch0_o;
  logic [W-1:0] ch1_o;
  logic         valid_o;
  logic         busy_o;
  logic         err_o;

  adc_acq_seq #(
    .Width         (W),
    .AvgLog2       (AVG),
    .PeriodCycles  (PER),
    .TimeoutCycles (TO)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (en),
    .din_i   (din),
    .eor_i   (eor),
    .strr_o  (strr_o),
    .ch_o    (ch_o),
    .ch0_o   (ch0_o),
    .ch1_o   (ch1_o),
    .valid_o (valid_o),
    .busy_o  (busy_o),
    .err_o   (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;
  int strr_stray = 0;

  // Reference model: running per-window sums and last published averages.
  int  win_n = 0;
  int  sum0 = 0;
  int  sum1 = 0;
  int  last0 = 0;
  int  last1 = 0;
  bit  exp_valid = 1'b0;

  always @(negedge clk) begin
    if (valid_o === 1'b1) valid_cnt++;
    if (err_o === 1'b1) err_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_pair(input int d0, input int d1);
    sum0 += d0;
    sum1 += d1;
    win_n++;
    exp_valid = 1'b0;
    if (win_n == NAVG) begin
      last0 = sum0 / NAVG;
      last1 = sum1 / NAVG;
      exp_valid = 1'b1;
      win_n = 0;
      sum0 = 0;
      sum1 = 0;
    end
  endtask

  task automatic model_idle();
    win_n = 0;
    sum0 = 0;
    sum1 = 0;
    exp_valid = 1'b0;
  endtask

  // Returns number of falling edges waited until strr_o is seen high.
  task automatic wait_strr(output int n);
    n = 0;
    while (strr_o !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("strr_arrives", strr_o, 1);
  endtask

  // Called on the falling edge that shows strr_o; ends on the edge after eor.
  task automatic drive_read(input logic [W-1:0] v, input int lat);
    @(negedge clk);
    if (strr_o) strr_stray++;
    repeat (lat) begin
      @(negedge clk);
      if (strr_o) strr_stray++;
    end
    eor = 1'b1;
    din = v;
    @(negedge clk);
    eor = 1'b0;
    din = W'($urandom);
  endtask

  task automatic run_pair(input logic [W-1:0] d0, input logic [W-1:0] d1,
                          input int lat0, input int lat1, input bit chk_gap);
    int n;
    wait_strr(n);
    if (chk_gap) check("pair_gap", n + 2, PER + 1);
    check("ch_start0", ch_o, 0);
    drive_read(d0, lat0);
    check("strr_ch1", strr_o, 1);
    check("ch_start1", ch_o, 1);
    drive_read(d1, lat1);
    check("strr_in_pair", strr_o, 0);
    model_pair(d0, d1);
    @(negedge clk);
    check("valid", valid_o, exp_valid);
    check("ch0_avg", ch0_o, last0);
    check("ch1_avg", ch1_o, last1);
    @(negedge clk);
    check("valid_width", valid_o, 0);
    check("no_strr_in_wait", strr_stray, 0);
  endtask

  typedef struct {
    logic [3:0][W-1:0] d0;
    logic [3:0][W-1:0] d1;
    logic [W-1:0]      e0;
    logic [W-1:0]      e1;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int n;
    int cnt;
    int first_idle;
    int vbefore;
    int strr_seen;

    tbl[0] = '{d0: {12'd105, 12'd102, 12'd101, 12'd100}, d1: {4{12'd4095}},
               e0: 12'd102, e1: 12'd4095};
    tbl[1] = '{d0: {4{12'd0}}, d1: {12'd3, 12'd0, 12'd0, 12'd0},
               e0: 12'd0, e1: 12'd0};
    tbl[2] = '{d0: {4{12'd4095}}, d1: {12'd4, 12'd3, 12'd2, 12'd1},
               e0: 12'd4095, e1: 12'd2};
    tbl[3] = '{d0: {12'd6, 12'd7, 12'd7, 12'd7}, d1: {4{12'd1}},
               e0: 12'd6, e1: 12'd1};

    rst = 1'b1;
    en  = 1'b0;
    eor = 1'b0;
    din = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_strr", strr_o, 0);
    check("rst_ch", ch_o, 0);
    check("rst_ch0", ch0_o, 0);
    check("rst_ch1", ch1_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_err", err_o, 0);
    repeat (2) @(negedge clk);
    check("idle_busy", busy_o, 0);

    en = 1'b1;
    wait_strr(n);
    check("startup_latency", n, 1);
    check("startup_ch", ch_o, 0);

    for (int t = 0; t < 4; t++) begin
      for (int p = 0; p < 4; p++)
        run_pair(tbl[t].d0[p], tbl[t].d1[p], p + 1, 2, !(t == 0 && p == 0));
      check("tbl_ch0", ch0_o, tbl[t].e0);
      check("tbl_ch1", ch1_o, tbl[t].e1);
    end
    check("valid_count_tbl", valid_cnt, 4);

    for (int w = 0; w < 3; w++)
      for (int p = 0; p < 4; p++)
        run_pair(W'($urandom), W'($urandom), $urandom_range(0, 6), $urandom_range(0, 6), 1'b1);

    // Disable during channel 0 of the second pair of a window.
    run_pair(12'd50, 12'd60, 1, 1, 1'b1);
    wait_strr(n);
    check("dis_gap", n + 2, PER + 1);
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    eor = 1'b1;
    din = 12'd70;
    @(negedge clk);
    eor = 1'b0;
    check("dis_strr_ch1", strr_o, 1);
    check("dis_ch1", ch_o, 1);
    drive_read(12'd80, 1);
    model_idle();
    first_idle = -1;
    vbefore = valid_cnt;
    strr_seen = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (strr_o) strr_seen++;
      if (first_idle < 0 && busy_o == 1'b0) first_idle = i;
    end
    check("dis_idle_at", first_idle, PER + 1);
    check("dis_no_valid", valid_cnt, vbefore);
    check("dis_no_strr", strr_seen, 0);
    check("dis_hold_ch0", ch0_o, last0);
    check("dis_hold_ch1", ch1_o, last1);

    en = 1'b1;
    wait_strr(n);
    check("reen_latency", n, 1);
    run_pair(12'd10, 12'd1, 0, 0, 1'b0);
    run_pair(12'd20, 12'd1, 3, 1, 1'b1);
    run_pair(12'd30, 12'd1, 1, 5, 1'b1);
    run_pair(12'd40, 12'd2, 2, 2, 1'b1);
    check("fresh_ch0", ch0_o, 25);
    check("fresh_ch1", ch1_o, 1);

`ifdef ADC_ACQ_TIMEOUT_EN
    wait_strr(n);
    check("to_ch_start", ch_o, 0);
    cnt = 0;
    while (err_o !== 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    // START cycle, then TO cycles in WAIT_EOR, then the retry START.
    check("to_latency0", cnt, TO + 1);
    check("to_retry_strr0", strr_o, 1);
    check("to_retry_ch0", ch_o, 0);
    drive_read(12'd300, 0);
    check("to_strr_ch1", strr_o, 1);
    cnt = 0;
    while (err_o !== 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("to_latency1", cnt, TO + 1);
    check("to_retry_strr1", strr_o, 1);
    check("to_retry_ch1", ch_o, 1);
    drive_read(12'd400, 2);
    model_pair(300, 400);
    @(negedge clk);
    check("to_valid", valid_o, exp_valid);
    repeat (3) @(negedge clk);
    eor = 1'b1;
    din = 12'd4000;
    @(negedge clk);
    eor = 1'b0;
    for (int p = 0; p < 3; p++)
      run_pair(W'($urandom), W'($urandom), $urandom_range(0, 4), $urandom_range(0, 4), 1'b0);
    check("to_err_count", err_cnt, 2);
`else
    check("err_never", err_cnt, 0);
`endif

    // Asynchronous reset while waiting for channel 0 end-of-read.
    wait_strr(n);
    @(negedge clk);
    check("pre_rst_ch0", ch0_o, last0);
    #2 rst = 1'b1;
    #1;
    check("arst_strr", strr_o, 0);
    check("arst_ch", ch_o, 0);
    check("arst_ch0", ch0_o, 0);
    check("arst_ch1", ch1_o, 0);
    check("arst_valid", valid_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_err", err_o, 0);
    en = 1'b0;
    vbefore = valid_cnt;
    @(negedge clk);
    rst = 1'b0;
    last0 = 0;
    last1 = 0;
    model_idle();
    eor = 1'b1;
    din = 12'd123;
    @(negedge clk);
    eor = 1'b0;
    repeat (30) @(negedge clk);
    check("arst_no_valid", valid_cnt, vbefore);
    check("arst_idle_busy", busy_o, 0);
    check("arst_idle_ch0", ch0_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
